// File: rtl/dual_rail_parity_sender_pkg.sv
// Shared types and helpers for the dual-rail parity sender.
// State encoding, error codes and the dual-rail token encoder.
package dual_rail_parity_sender_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        WAIT_ACK,
        CLEAR,
        WAIT_NULL,
        DONE,
        FAULT
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_BOTH     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Returns {bit1, bit0} for one data bit: exactly one rail high.
    function automatic logic [1:0] dual_rail(input logic d);
        return d ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sync_2ff_vec.sv
// Generic N-bit, multi-stage flop synchroniser.
// Each bit is synchronised independently; reset clears every stage.
module sync_2ff_vec #(
    parameter int N      = 2,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] ff [STAGES];

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) ff[i] <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/dual_rail_parity_sender.sv
// Clocked source of the dual-rail four-phase parity channel.
// Sends words LSB-first and checks each acknowledge against a parity model.
module dual_rail_parity_sender #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             bit0,
    output logic             bit1,
    input  logic             parity0,
    input  logic             parity1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [1:0]       out_err
);

    import dual_rail_parity_sender_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    count, count_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic             exp, exp_n, exp_next;
    logic [1:0]       rails_n;
    logic             par_n;
    logic [1:0]       err_n;
    logic [1:0]       p_sync;
    logic             p0s, p1s;

    sync_2ff_vec #(
        .N      (2),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({parity1, parity0}),
        .q     (p_sync)
    );

    assign p0s = p_sync[0];
    assign p1s = p_sync[1];

    // The responder toggles its running parity on every zero bit.
    assign exp_next = exp ^ ~shreg[0];

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);

    // Register all FSM and datapath state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            count      <= '0;
            tmr        <= '0;
            exp        <= 1'b0;
            bit0       <= 1'b0;
            bit1       <= 1'b0;
            out_parity <= 1'b0;
            out_err    <= ERR_NONE;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            count      <= count_n;
            tmr        <= tmr_n;
            exp        <= exp_n;
            bit1       <= rails_n[1];
            bit0       <= rails_n[0];
            out_parity <= par_n;
            out_err    <= err_n;
        end
    end

    // Next-state, rail and result logic for the four-phase handshake.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        count_n = count;
        tmr_n   = tmr;
        exp_n   = exp;
        rails_n = {bit1, bit0};
        par_n   = out_parity;
        err_n   = out_err;
        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shreg_n = in_data;
                    count_n = '0;
                    err_n   = ERR_NONE;
                    state_n = SET;
                end
            end
            SET: begin
                rails_n = dual_rail(shreg[0]);
                tmr_n   = '0;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (p0s || p1s) begin
                    par_n = p1s;
                    exp_n = exp_next;
                    if (out_err == ERR_NONE) begin
                        if (p0s && p1s) begin
                            err_n = ERR_BOTH;
                        end else if (p1s != exp_next) begin
                            err_n = ERR_MISMATCH;
                        end
                    end
                    state_n = CLEAR;
                end else if (tmr == TMAX) begin
                    rails_n = 2'b00;
                    err_n   = ERR_TIMEOUT;
                    state_n = DONE;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            CLEAR: begin
                rails_n = 2'b00;
                tmr_n   = '0;
                state_n = WAIT_NULL;
            end
            WAIT_NULL: begin
                if (!p0s && !p1s) begin
                    if (count == LAST) begin
                        state_n = DONE;
                    end else begin
                        shreg_n = shreg >> 1;
                        count_n = count + CW'(1);
                        state_n = SET;
                    end
                end else if (tmr == TMAX) begin
                    rails_n = 2'b00;
                    err_n   = ERR_TIMEOUT;
                    state_n = DONE;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = (out_err == ERR_TIMEOUT) ? FAULT : IDLE;
                end
            end
            FAULT: begin
                rails_n = 2'b00;
            end
            default: begin
                rails_n = 2'b00;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dual_rail_parity_sender.sv
// Bench for dual_rail_parity_sender with a behavioural responder.
// A word-level parity model predicts tokens and results.
module tb_dual_rail_parity_sender;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         bit0, bit1;
    logic         parity0, parity1;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_parity;
    logic [1:0]   out_err;

    int vectors = 0;
    int miscompares = 0;

    // responder control: 0 normal, 1 wrong rail, 2 both rails, 3 silent
    int inj_mode = 0;
    int inj_bit = 0;

    logic [1:0] tokq[$];
    logic [2:0] resq[$];
    logic       mp = 1'b0;
    logic       lastpar = 1'b0;

    dual_rail_parity_sender #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .bit0       (bit0),
        .bit1       (bit1),
        .parity0    (parity0),
        .parity1    (parity1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Self-timed responder: toggles on zero tokens, returns to null.
    initial begin
        logic rp;
        int   wb;
        rp = 1'b0;
        wb = 0;
        parity0 = 1'b0;
        parity1 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                rp = 1'b0;
                wb = 0;
                parity0 = 1'b0;
                parity1 = 1'b0;
            end else if ((bit0 || bit1) && !parity0 && !parity1) begin
                if (inj_mode != 3) begin
                    if (bit0) rp = ~rp;
                    if (inj_mode == 2 && wb == inj_bit) begin
                        parity0 = 1'b1;
                        parity1 = 1'b1;
                    end else if (inj_mode == 1 && wb == inj_bit) begin
                        parity0 = rp;
                        parity1 = ~rp;
                    end else begin
                        parity0 = ~rp;
                        parity1 = rp;
                    end
                    wb = (wb + 1) % W;
                end
            end else if (!bit0 && !bit1) begin
                parity0 = 1'b0;
                parity1 = 1'b0;
            end
        end
    end

    // Compare process: rail exclusivity, token order and results.
    initial begin
        logic [1:0] prev, cur;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            cur = {bit1, bit0};
            if (reset) begin
                prev = 2'b00;
            end else begin
                check("rails_exclusive", 32'(bit0 & bit1), 0);
                if (cur != 2'b00 && prev == 2'b00) begin
                    if (tokq.size() == 0) check("token_unexpected", 32'(cur), 0);
                    else check("token", 32'(cur), 32'(tokq.pop_front()));
                end
                if (out_valid && out_ready) begin
                    if (resq.size() == 0) check("result_unexpected", 1, 0);
                    else check("result", 32'({out_parity, out_err}),
                               32'(resq.pop_front()));
                end
                prev = cur;
            end
        end
    end

    task automatic model_word(input logic [W-1:0] w, input int mode,
                              input int ibit);
        logic       m, lp;
        logic [1:0] e;
        m = mp;
        lp = lastpar;
        e = 2'b00;
        if (mode == 3) begin
            tokq.push_back(w[0] ? 2'b10 : 2'b01);
            resq.push_back({lastpar, 2'b11});
        end else begin
            for (int i = 0; i < W; i++) begin
                tokq.push_back(w[i] ? 2'b10 : 2'b01);
                if (!w[i]) m = ~m;
                if (mode == 2 && i == ibit) begin
                    lp = 1'b1;
                    if (e == 2'b00) e = 2'b10;
                end else if (mode == 1 && i == ibit) begin
                    lp = ~m;
                    if (e == 2'b00) e = 2'b01;
                end else begin
                    lp = m;
                end
            end
            mp = m;
            lastpar = lp;
            resq.push_back({lp, e});
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input int mode,
                             input int ibit, input logic [2:0] lit,
                             input int hold);
        int n;
        int lat;
        int want_lat;
        model_word(w, mode, ibit);
        want_lat = (mode == 3) ? (1 + TO) : (W * (4 + 2 * S));
        @(posedge clk);
        #1;
        inj_mode = mode;
        inj_bit = ibit;
        out_ready = (hold > 0) ? 1'b0 : 1'b1;
        in_valid = 1'b1;
        in_data = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = '0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 4 * TO + 200) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", 32'(out_valid), 1);
        check("latency", lat, want_lat);
        check("literal", 32'({out_parity, out_err}), 32'(lit));
        if (mode == 3) check("timeout_rails", 32'({bit1, bit0}), 0);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_result", 32'({out_parity, out_err}), 32'(lit));
            check("hold_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        inj_mode = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        inj_mode = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tokq.delete();
        resq.delete();
        mp = 1'b0;
        lastpar = 1'b0;
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rails", 32'({bit1, bit0}), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", 32'({out_parity, out_err}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);

        send_word(4'b0000, 0, 0, 3'b0_00, 0);
        send_word(4'b1011, 0, 0, 3'b1_00, 0);
        send_word(4'b1111, 0, 0, 3'b1_00, 0);
        send_word(4'b0000, 1, 2, 3'b1_01, 0);
        send_word(4'b0001, 0, 0, 3'b0_00, 0);
        send_word(4'b0101, 2, 0, 3'b0_10, 0);
        send_word(4'b0010, 0, 0, 3'b1_00, 10);

        // reset while a rail is high
        tokq.push_back(2'b01);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = 4'b0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(bit0 || bit1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midword_rail_high", 32'(bit0 | bit1), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midword_rst_rails", 32'({bit1, bit0}), 0);
        check("midword_rst_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tokq.delete();
        resq.delete();
        mp = 1'b0;
        lastpar = 1'b0;

        send_word(4'b0001, 3, 0, 3'b0_11, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("fault_in_ready", 32'(in_ready), 0);
            check("fault_rails", 32'({bit1, bit0}), 0);
        end
        do_reset();
        @(negedge clk);
        check("recover_in_ready", 32'(in_ready), 1);
        send_word(4'b0000, 0, 0, 3'b0_00, 0);

        repeat (4) @(negedge clk);
        check("queues_drained", tokq.size() + resq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
